// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, types and small-sigma functions
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;
  localparam int SCHED_WORDS   = 16;
  localparam int WORD_W        = 32;

  localparam logic [5:0] LAST_ROUND = 6'(SHA256_ROUNDS - 1);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  function automatic word_t sigma0_small(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t sigma1_small(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_sched_if.sv
// rtl/sha256_msg_sched_if.sv - block-in / schedule-word-out bus of the message scheduler
interface sha256_msg_sched_if;
  import sha256_pkg::*;

  logic                          i_start;
  logic [SCHED_WORDS*WORD_W-1:0] i_block;
  logic                          i_hold;
  logic [6:0]                    o_coef_num;
  word_t                         o_w;
  logic [5:0]                    o_round;
  logic                          o_valid;
  logic                          o_last;
  logic                          o_busy;

  modport master (
    output i_start, i_block, i_hold,
    input  o_coef_num, o_w, o_round, o_valid, o_last, o_busy
  );

  modport slave (
    input  i_start, i_block, i_hold,
    output o_coef_num, o_w, o_round, o_valid, o_last, o_busy
  );

endinterface

// File: rtl/sha256_small_sigma.sv
// rtl/sha256_small_sigma.sv - combinational SHA-256 small sigma0/sigma1 of one word
module sha256_small_sigma
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t s0,
  output word_t s1
);

  assign s0 = sigma0_small(x);
  assign s1 = sigma1_small(x);

endmodule

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - expands one 512-bit block into W[0..63] aligned with the K ROM
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  sha256_msg_sched_if.slave  bus
);

  sched_state_t r_state, w_state_nxt;
  word_t        r_win [SCHED_WORDS];
  word_t        w_win_nxt [SCHED_WORDS];
  logic [5:0]   r_t, w_t_nxt;
  logic [6:0]   r_coef_num, w_coef_nxt;
  word_t        r_w, w_w_nxt;
  logic [5:0]   r_round, w_round_nxt;
  logic         r_valid, w_valid_nxt;
  logic         r_last, w_last_nxt;

  word_t w_s0_win1;
  word_t w_s1_win14;
  word_t w_s1_win1_unused;
  word_t w_s0_win14_unused;
  word_t w_new;

  sha256_small_sigma u_sigma_win1 (
    .x  (r_win[1]),
    .s0 (w_s0_win1),
    .s1 (w_s1_win1_unused)
  );

  sha256_small_sigma u_sigma_win14 (
    .x  (r_win[14]),
    .s0 (w_s0_win14_unused),
    .s1 (w_s1_win14)
  );

  assign w_new = w_s1_win14 + r_win[9] + w_s0_win1 + r_win[0];

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_t_nxt     = r_t;
    w_coef_nxt  = r_coef_num;
    w_w_nxt     = r_w;
    w_round_nxt = r_round;
    w_valid_nxt = 1'b0;
    w_last_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // ROM address parked on 0 so K[0] is already latched when W[0] leaves
        w_coef_nxt = 7'd0;
        if (bus.i_start) begin
          for (int k = 0; k < SCHED_WORDS; k++) begin
            w_win_nxt[k] = bus.i_block[(SCHED_WORDS-1-k)*WORD_W +: WORD_W];
          end
          w_t_nxt     = 6'd0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.i_hold) begin
          w_w_nxt     = r_win[0];
          w_round_nxt = r_t;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (r_t == LAST_ROUND);
          for (int k = 0; k < SCHED_WORDS-1; k++) begin
            w_win_nxt[k] = r_win[k+1];
          end
          w_win_nxt[SCHED_WORDS-1] = w_new;
          if (r_t != LAST_ROUND) begin
            w_t_nxt    = r_t + 6'd1;
            w_coef_nxt = {1'b0, r_t + 6'd1};
          end else begin
            w_coef_nxt  = 7'd0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_coef_nxt  = 7'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      for (int k = 0; k < SCHED_WORDS; k++) begin
        r_win[k] <= '0;
      end
      r_t        <= '0;
      r_coef_num <= '0;
      r_w        <= '0;
      r_round    <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_win      <= w_win_nxt;
      r_t        <= w_t_nxt;
      r_coef_num <= w_coef_nxt;
      r_w        <= w_w_nxt;
      r_round    <= w_round_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign bus.o_coef_num = r_coef_num;
  assign bus.o_w        = r_w;
  assign bus.o_round    = r_round;
  assign bus.o_valid    = r_valid;
  assign bus.o_last     = r_last;
  assign bus.o_busy     = (r_state == ST_RUN);

endmodule
